// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the dual-port UART scheduler.
package uart_sched_pkg;

  localparam int NUM_PORTS = 2;

  typedef logic port_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    SWITCH,
    LAUNCH,
    WAIT_START,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter: on a tie the port that was not
// granted last wins, otherwise the single requester wins.
module rr_arb2
  import uart_sched_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            last,
  output port_idx_t            winner
);

  // Pick the lone requester, or alternate away from the last grant on a tie.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = ~last;
    end
  end

endmodule

// File: rtl/uart_port_scheduler.sv
// Shares one UART TX/RX interface between two byte requesters.
// Round-robin grant, port switching with a settle delay, launch/start timeout
// and RX tagging with the active port.
// Optional macro UART_SCHED_STATS_EN adds per-port completed-byte counters.
module uart_port_scheduler
  import uart_sched_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_PORTS-1:0]      req_valid,
  input  logic [NUM_PORTS-1:0][7:0] req_byte,
  output logic [NUM_PORTS-1:0]      req_ready,
  output logic [NUM_PORTS-1:0]      done,
  output logic                      timeout_err,
  output logic                      port_select,
  output logic                      transmit,
  output logic [7:0]                tx_byte,
  input  logic                      is_transmitting,
  input  logic                      is_receiving,
  input  logic                      received,
  input  logic [7:0]                rx_byte,
  output logic                      rx_valid,
  output logic                      rx_port,
  output logic [7:0]                rx_data
`ifdef UART_SCHED_STATS_EN
  ,
  output logic [15:0]               tx_count_0,
  output logic [15:0]               tx_count_1
`endif
);

  localparam int CNT_MAXV = (SETTLE_CYCLES > START_TIMEOUT) ? SETTLE_CYCLES : START_TIMEOUT;
  localparam int CNT_W    = $clog2(CNT_MAXV + 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_TIMEOUT - 1);

  state_t                state_q, state_d;
  port_idx_t             grant_q, grant_d;
  port_idx_t             last_grant_q, last_grant_d;
  logic                  port_select_q, port_select_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  transmit_q, transmit_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic [NUM_PORTS-1:0]  req_ready_q, req_ready_d;
  logic [NUM_PORTS-1:0]  done_q, done_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  rx_valid_q, rx_port_q;
  logic [7:0]            rx_data_q;
  port_idx_t             winner;

  rr_arb2 u_arb (
    .req    (req_valid),
    .last   (last_grant_q),
    .winner (winner)
  );

  // Saturating increment shared by the settle and start-timeout phases.
  always_comb begin
    cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state and registered-output logic for the transfer sequencer.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    port_select_d = port_select_q;
    cnt_d         = cnt_q;
    transmit_d    = 1'b0;
    tx_byte_d     = tx_byte_q;
    req_ready_d   = '0;
    done_d        = '0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid != '0) begin
          if (winner == port_select_q) begin
            grant_d = winner;
            state_d = LAUNCH;
          end else if (!is_receiving && !is_transmitting) begin
            port_select_d = ~port_select_q;
            grant_d       = winner;
            cnt_d         = '0;
            state_d       = SWITCH;
          end else if (req_valid[port_select_q]) begin
            grant_d = port_select_q;
            state_d = LAUNCH;
          end
        end
      end

      SWITCH: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = LAUNCH;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      LAUNCH: begin
        if (req_valid[grant_q]) begin
          transmit_d           = 1'b1;
          tx_byte_d            = req_byte[grant_q];
          req_ready_d[grant_q] = 1'b1;
          cnt_d                = '0;
          state_d              = WAIT_START;
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_START: begin
        if (is_transmitting) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == START_LAST) begin
          timeout_err_d = 1'b1;
          last_grant_d  = grant_q;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_DONE: begin
        if (!is_transmitting) begin
          done_d[grant_q] = 1'b1;
          last_grant_d    = grant_q;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      port_select_q <= 1'b0;
      cnt_q         <= '0;
      transmit_q    <= 1'b0;
      tx_byte_q     <= '0;
      req_ready_q   <= '0;
      done_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      port_select_q <= port_select_d;
      cnt_q         <= cnt_d;
      transmit_q    <= transmit_d;
      tx_byte_q     <= tx_byte_d;
      req_ready_q   <= req_ready_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // RX capture: one-cycle delayed copy tagged with the pre-edge port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_port_q  <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= received;
      rx_port_q  <= port_select_q;
      rx_data_q  <= rx_byte;
    end
  end

  assign req_ready   = req_ready_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign port_select = port_select_q;
  assign transmit    = transmit_q;
  assign tx_byte     = tx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign rx_port     = rx_port_q;
  assign rx_data     = rx_data_q;

`ifdef UART_SCHED_STATS_EN
  logic [15:0] tx_count_0_q, tx_count_0_d;
  logic [15:0] tx_count_1_q, tx_count_1_d;

  // Completed-byte counters advance with the done pulse and wrap naturally.
  always_comb begin
    tx_count_0_d = tx_count_0_q + {15'd0, done_d[0]};
    tx_count_1_d = tx_count_1_q + {15'd0, done_d[1]};
  end

  // Completed-byte counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_count_0_q <= '0;
      tx_count_1_q <= '0;
    end else begin
      tx_count_0_q <= tx_count_0_d;
      tx_count_1_q <= tx_count_1_d;
    end
  end

  assign tx_count_0 = tx_count_0_q;
  assign tx_count_1 = tx_count_1_q;
`endif

endmodule
